// File: rtl/div_unit.sv
// Iterative 32-bit divider (DIV/DIVU): one radix-2 restoring step per clock,
// sign fixup at the end, and a result held until the requester drops div_start_i.
module div_unit (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        div_start_i,
  input  logic        signed_div_i,
  input  logic [31:0] div_opdata1_i,
  input  logic [31:0] div_opdata2_i,
  input  logic        annul_i,
  output logic [63:0] div_result_o,
  output logic        div_ready_o,
  output logic        div_busy_o,
  output logic [1:0]  div_state_o
);

  // Handshake: the requester raises div_start_i and holds it; the result is
  // valid while div_ready_o=1 and is consumed when div_start_i drops in END.
  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_t;

  div_state_t  state, state_next;
  logic [5:0]  cnt;
  logic        signed_r;
  logic        sign1_r;
  logic        sign2_r;
  logic [31:0] divisor_r;
  // [64:32] partial remainder, [31:0] dividend bits shifting out / quotient shifting in
  logic [64:0] work_r;

  logic [31:0] op1_abs;
  logic [31:0] op2_abs;
  logic [64:0] shifted;
  logic [32:0] diff;
  logic [64:0] step_val;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign div_busy_o  = (state != DIV_FREE);
  assign div_state_o = state;

  always_comb begin
    op1_abs  = (signed_div_i && div_opdata1_i[31]) ? (~div_opdata1_i + 32'd1) : div_opdata1_i;
    op2_abs  = (signed_div_i && div_opdata2_i[31]) ? (~div_opdata2_i + 32'd1) : div_opdata2_i;
    shifted  = {work_r[63:0], 1'b0};
    diff     = shifted[64:32] - {1'b0, divisor_r};
    // Partial remainder is always below 2*divisor, so bit 32 is a reliable sign.
    if (!diff[32]) begin
      step_val = {diff, shifted[31:1], 1'b1};
    end else begin
      step_val = shifted;
    end
    quo_fix = (signed_r && (sign1_r ^ sign2_r)) ? (~work_r[31:0] + 32'd1) : work_r[31:0];
    rem_fix = (signed_r && sign1_r) ? (~work_r[63:32] + 32'd1) : work_r[63:32];
  end

  always_comb begin
    state_next = state;
    if (annul_i) begin
      state_next = DIV_FREE;
    end else begin
      case (state)
        DIV_FREE: begin
          if (div_start_i) begin
            state_next = (div_opdata2_i == 32'd0) ? DIV_BY_ZERO : DIV_ON;
          end
        end
        DIV_BY_ZERO: state_next = DIV_END;
        DIV_ON: begin
          if (cnt == 6'd32) begin
            state_next = DIV_END;
          end
        end
        DIV_END: begin
          if (!div_start_i) begin
            state_next = DIV_FREE;
          end
        end
        default: state_next = DIV_FREE;
      endcase
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state        <= DIV_FREE;
      cnt          <= 6'd0;
      signed_r     <= 1'b0;
      sign1_r      <= 1'b0;
      sign2_r      <= 1'b0;
      divisor_r    <= 32'd0;
      work_r       <= 65'd0;
      div_result_o <= 64'd0;
      div_ready_o  <= 1'b0;
    end else if (annul_i) begin
      state        <= DIV_FREE;
      cnt          <= 6'd0;
      work_r       <= 65'd0;
      div_result_o <= 64'd0;
      div_ready_o  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        DIV_FREE: begin
          cnt <= 6'd0;
          if (div_start_i) begin
            signed_r  <= signed_div_i;
            sign1_r   <= div_opdata1_i[31];
            sign2_r   <= div_opdata2_i[31];
            divisor_r <= op2_abs;
            work_r    <= {33'd0, op1_abs};
          end
        end
        DIV_BY_ZERO: begin
          work_r <= 65'd0;
        end
        DIV_ON: begin
          if (cnt == 6'd32) begin
            work_r <= {1'b0, rem_fix, quo_fix};
            cnt    <= 6'd0;
          end else begin
            work_r <= step_val;
            cnt    <= cnt + 6'd1;
          end
        end
        DIV_END: begin
          if (div_start_i) begin
            div_result_o <= work_r[63:0];
            div_ready_o  <= 1'b1;
          end else begin
            div_result_o <= 64'd0;
            div_ready_o  <= 1'b0;
          end
        end
        default: begin
          cnt <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus random DIV/DIVU operations
// checked against an arithmetic reference model through an expected queue.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        busy;
  logic [1:0]  state_dbg;

  int          n_cmp;
  int          n_fail;
  int          exp_lat;
  logic [63:0] exp_q[$];

  div_unit dut (
    .cpu_clk_50M  (clk),
    .cpu_rst_n    (rst_n),
    .div_start_i  (start),
    .signed_div_i (sgn),
    .div_opdata1_i(op1),
    .div_opdata2_i(op2),
    .annul_i      (annul),
    .div_result_o (result),
    .div_ready_o  (ready),
    .div_busy_o   (busy),
    .div_state_o  (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer division truncating toward zero.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // driver tasks
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    sgn   = s;
    op1   = a;
    op2   = b;
    exp_q.push_back(ref_div(s, a, b));
    exp_lat = (b == 32'd0) ? 3 : 35;
  endtask

  task automatic wait_ready(input bit scramble);
    int n;
    logic [63:0] exp;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("busy_after_start", {64'd0, busy}, 65'd1);
        if (scramble) begin
          sgn = ~sgn;
          op1 = $urandom();
          op2 = $urandom();
        end
      end
    end while (!ready && n < 60);
    check("latency", 65'(n), 65'(exp_lat));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    check("result", {1'b0, result}, {1'b0, exp});
  endtask

  task automatic hold_check(input int k);
    logic [64:0] snap;
    snap = {ready, result};
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_stable", {ready, result}, snap);
    end
  endtask

  task automatic release_check();
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("release_out", {ready, result}, 65'd0);
    check("release_busy", {64'd0, busy}, 65'd0);
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit scramble);
    issue(s, a, b);
    wait_ready(scramble);
    hold_check(hold);
    release_check();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    sgn    = 1'b0;
    op1    = 32'd0;
    op2    = 32'd0;
    annul  = 1'b0;
    exp_lat = 0;
    repeat (3) @(negedge clk);
    check("reset_out", {ready, result}, 65'd0);
    check("reset_state", {62'd0, busy, state_dbg}, 65'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed values
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 10, 1'b1);
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 2, 1'b1);
    run_op(1'b1, 32'h0000_0007, 32'h0000_0002, 2, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b1);
    run_op(1'b0, 32'h0000_0005, 32'h0000_0000, 3, 1'b1);
    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1, 1'b0);
    run_op(1'b0, 32'h0000_0003, 32'h0000_0009, 1, 1'b0);

    // annul after 17 divide steps
    issue(1'b0, 32'h1234_5678, 32'h0000_0123);
    repeat (18) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("annul_out", {ready, result}, 65'd0);
    check("annul_state", {62'd0, busy, state_dbg}, 65'd0);
    void'(exp_q.pop_front());
    annul = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("annul_idle", {63'd0, busy, ready}, 65'd0);

    // asynchronous reset while a result is presented
    issue(1'b1, 32'hFFFF_FF00, 32'h0000_0007);
    wait_ready(1'b0);
    #5 rst_n = 1'b0;
    #1;
    check("rst_end_out", {ready, result}, 65'd0);
    check("rst_end_state", {62'd0, busy, state_dbg}, 65'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset mid-operation, then no stale result
    issue(1'b0, 32'hCAFE_F00D, 32'h0000_0BAD);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_out", {ready, result}, 65'd0);
    check("rst_mid_busy", {64'd0, busy}, 65'd0);
    void'(exp_q.pop_front());
    start = 1'b0;
    #3 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_mid_stale", {busy, ready, result}, 66'd0);

    // random operations
    for (int i = 0; i < 24; i++) begin
      run_op(1'($urandom_range(0, 1)), pick(), pick(),
             int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as below.
REQ-002 The block SHALL have port cpu_clk_50M, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 The block SHALL have port cpu_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port div_start_i, input, 1 bit: divide request from the execute stage, held high until the result is consumed.
REQ-005 The block SHALL have port signed_div_i, input, 1 bit: 1 = DIV (two's complement), 0 = DIVU.
REQ-006 The block SHALL have port div_opdata1_i, input, 32 bits: dividend.
REQ-007 The block SHALL have port div_opdata2_i, input, 32 bits: divisor.
REQ-008 The block SHALL have port annul_i, input, 1 bit: cancel any operation in progress (pipeline flush or exception).
REQ-009 The block SHALL have port div_result_o, output, 64 bits: {remainder[63:32] to HI, quotient[31:0] to LO}.
REQ-010 The block SHALL have port div_ready_o, output, 1 bit: div_result_o is valid.
REQ-011 The block SHALL have port div_busy_o, output, 1 bit: state is not FREE.

Function
REQ-012 The block SHALL implement four states: FREE, BY_ZERO, ON, END.
REQ-013 In FREE with div_start_i=1 and annul_i=0, the block SHALL latch signed_div_i, the operand sign bits, |dividend| and |divisor| (magnitudes only when signed), then go to BY_ZERO if the divisor is 0, else to ON with cnt=0.
REQ-014 After the capture in FREE, the block SHALL ignore changes on the operand and signed_div_i inputs until it next returns to FREE.
REQ-015 In ON the block SHALL perform one radix-2 restoring step per cycle on a 65-bit {partial remainder, dividend} register: trial = rem - divisor; if non-negative, shift in quotient bit 1 and keep trial, else shift in 0 and keep rem; cnt increments by 1.
REQ-016 In ON, when cnt==32, the block SHALL apply sign fixup and go to END: quotient is negated if signed and the operand signs differ; remainder is negated if signed and the dividend is negative.
REQ-017 In BY_ZERO the block SHALL force quotient=0 and remainder=0 and go to END on the next edge.
REQ-018 In END the block SHALL register div_result_o = {remainder, quotient} and set div_ready_o=1.
REQ-019 In END the block SHALL hold div_ready_o and div_result_o stable while div_start_i stays high.
REQ-020 In END, when div_start_i=0, the block SHALL go to FREE with div_ready_o=0 and div_result_o=0 on that same edge.
REQ-021 Latency SHALL be: divisor!=0 gives div_ready_o=1 after the 35th rising edge counted from the edge that samples start (1 capture + 32 steps + 1 fixup + 1 END); divisor==0 gives div_ready_o=1 after the 3rd edge.
REQ-022 annul_i=1 on any edge SHALL force FREE, cnt=0, div_ready_o=0 and div_result_o=0, taking priority over div_start_i.
REQ-023 Signed -2^31 / -1 SHALL return quotient 0x80000000 and remainder 0, with no trap.
REQ-024 When div_start_i is held high across END-to-FREE (no drop), the block SHALL stay in END and SHALL NOT start a second operation.
REQ-025 div_start_i falling while in ON or BY_ZERO SHALL NOT abort the operation; only annul_i or reset aborts.
REQ-026 div_busy_o SHALL equal 1 in BY_ZERO, ON and END.

Reset
REQ-027 cpu_rst_n=0 SHALL immediately (asynchronously) set state=FREE, cnt=0, all datapath registers to 0, div_result_o=0, div_ready_o=0 and div_busy_o=0.
REQ-028 Reset deasserted mid-operation SHALL resume from FREE, and no stale result SHALL be presented.

Verification
REQ-029 Unsigned: DIVU 0xFFFFFFFF / 0x00000010 -> after 35 edges div_ready_o=1, div_result_o=0x0000000F_0FFFFFFF.
REQ-030 Signed: DIV 0xFFFFFFF9 (-7) / 0x00000002 -> div_result_o=0xFFFFFFFF_FFFFFFFD; DIV 7/2 -> 0x00000001_00000003.
REQ-031 Corner: DIV 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000; DIVU 5/0 -> ready after 3 edges, result 0.
REQ-032 Handshake: hold start for 10 cycles after ready -> result stable; drop start -> next edge ready=0, result=0, busy=0; operands changed after capture -> result unchanged.
REQ-033 Annul/reset: assert annul_i at step 17 -> next edge FREE, ready=0; pulse cpu_rst_n low between edges -> outputs 0 without waiting for a clock edge.
